// File: rtl/cache_requester.sv
// Queues client read/write commands and replays them one at a time onto a
// cache port with registered read output, returning read results in order.
module cache_requester #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [31:0] cmd_address,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_address,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic        mode,
  input  logic [31:0] cache_out,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [31:0]        address_reg, address_next;
  logic [31:0]        data_reg, data_next;
  logic               mode_reg, mode_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [31:0]        rsp_data_reg, rsp_data_next;
  logic [31:0]        rsp_address_reg, rsp_address_next;
  logic [15:0]        rd_count_reg, rd_count_next;
  logic [15:0]        wr_count_reg, wr_count_next;

  logic               fifo_mode [FIFO_DEPTH];
  logic [31:0]        fifo_addr [FIFO_DEPTH];
  logic [31:0]        fifo_data [FIFO_DEPTH];

  logic push, pop;

  assign cmd_ready = (count_reg < CNT_W'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_reg == IDLE) && (count_reg != '0);

  // Storage entries carry no reset; occupancy alone defines what is valid.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          fifo_mode[gi] <= cmd_mode;
          fifo_addr[gi] <= cmd_address;
          fifo_data[gi] <= cmd_data;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    address_next     = address_reg;
    data_next        = data_reg;
    mode_next        = mode_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_data_next    = rsp_data_reg;
    rsp_address_next = rsp_address_reg;
    rd_count_next    = rd_count_reg;
    wr_count_next    = wr_count_reg;

    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase

    case (state_reg)
      IDLE: begin
        if (pop) begin
          address_next = fifo_addr[rd_ptr_reg];
          data_next    = fifo_data[rd_ptr_reg];
          mode_next    = fifo_mode[rd_ptr_reg];
          state_next   = ISSUE;
        end else begin
          mode_next = 1'b0;
        end
      end
      ISSUE: begin
        // mode_reg still holds the command type; a write drops mode here so
        // the cache sees exactly one write edge.
        if (mode_reg) begin
          mode_next  = 1'b0;
          state_next = IDLE;
          if (wr_count_reg != 16'hFFFF) wr_count_next = wr_count_reg + 16'd1;
        end else begin
          state_next = WAIT;
          if (rd_count_reg != 16'hFFFF) rd_count_next = rd_count_reg + 16'd1;
        end
      end
      WAIT: begin
        rsp_data_next    = cache_out;
        rsp_address_next = address_reg;
        rsp_valid_next   = 1'b1;
        state_next       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      address_reg     <= '0;
      data_reg        <= '0;
      mode_reg        <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_address_reg <= '0;
      rd_count_reg    <= '0;
      wr_count_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      address_reg     <= address_next;
      data_reg        <= data_next;
      mode_reg        <= mode_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_address_reg <= rsp_address_next;
      rd_count_reg    <= rd_count_next;
      wr_count_reg    <= wr_count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  assign address     = address_reg;
  assign data        = data_reg;
  assign mode        = mode_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_address = rsp_address_reg;
  assign rd_count    = rd_count_reg;
  assign wr_count    = wr_count_reg;

endmodule

// File: tb/tb_cache_requester.sv
// Directed bench for cache_requester with a behavioural registered-read cache.
module tb_cache_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_mode = 1'b0;
  logic [31:0] cmd_address = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [31:0] rsp_address;
  logic [31:0] address;
  logic [31:0] data;
  logic        mode;
  logic [31:0] cache_out = '0;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int n_cmp = 0;
  int n_err = 0;

  cache_requester #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_address(cmd_address), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_address(rsp_address),
    .address(address), .data(data), .mode(mode), .cache_out(cache_out),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Cache model: registered read, writes on every edge with mode high.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wlog [64];
  int          wn = 0;

  always @(posedge clk) begin
    if (mem.exists(address)) cache_out <= mem[address];
    else                     cache_out <= '0;
    if (mode) begin
      mem[address] = data;
      if (wn < 64) wlog[wn] = address;
      wn = wn + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_mode = m; cmd_address = a; cmd_data = d;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    int base;
    // Reset
    tick(); tick();
    rst = 1'b0;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_address", rsp_address, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_mode", {31'd0, mode}, 32'd0);
    check("rst_rd_count", {16'd0, rd_count}, 32'd0);
    check("rst_wr_count", {16'd0, wr_count}, 32'd0);

    // Write 0x10 <= DEADBEEF: mode high for exactly the cycle after E1
    push(1'b1, 32'h10, 32'hDEADBEEF);
    check("wr_e0_mode", {31'd0, mode}, 32'd0);
    tick();
    check("wr_e1_mode", {31'd0, mode}, 32'd1);
    check("wr_e1_address", address, 32'h10);
    check("wr_e1_data", data, 32'hDEADBEEF);
    tick();
    check("wr_e2_mode", {31'd0, mode}, 32'd0);
    check("wr_e2_wr_count", {16'd0, wr_count}, 32'd1);

    // Read 0x10: rsp_valid only after E3
    push(1'b0, 32'h10, 32'h0);
    check("rd_e0_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("rd_e1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rd_e1_mode", {31'd0, mode}, 32'd0);
    tick();
    check("rd_e2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rd_e2_rd_count", {16'd0, rd_count}, 32'd1);
    tick();
    check("rd_e3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_e3_rsp_data", rsp_data, 32'hDEADBEEF);
    check("rd_e3_rsp_address", rsp_address, 32'h10);

    // Response stalled 6 cycles while a write waits in the queue
    for (int i = 0; i < 6; i++) begin
      if (i == 0) push(1'b1, 32'h20, 32'h11111111);
      else        tick();
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_data", rsp_data, 32'hDEADBEEF);
      check("stall_mode", {31'd0, mode}, 32'd0);
      check("stall_wr_count", {16'd0, wr_count}, 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    check("accept_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("post_accept_mode", {31'd0, mode}, 32'd1);
    check("post_accept_address", address, 32'h20);
    check("post_accept_data", data, 32'h11111111);
    tick();
    check("post_accept_mode_clr", {31'd0, mode}, 32'd0);
    check("post_accept_wr_count", {16'd0, wr_count}, 32'd2);

    // Same-index different-tag writes, then read back 0x0
    push(1'b1, 32'h0, 32'hA5A5A5A5);
    push(1'b1, 32'h100, 32'h5A5A5A5A);
    push(1'b0, 32'h0, 32'h0);
    wait_rsp("alias_rsp_wait");
    check("alias_rsp_data", rsp_data, 32'hA5A5A5A5);
    check("alias_rsp_address", rsp_address, 32'h0);
    tick(); tick();
    check("alias_wr_count", {16'd0, wr_count}, 32'd4);
    check("alias_rd_count", {16'd0, rd_count}, 32'd2);

    // Fill the queue behind a stalled response
    rsp_ready = 1'b0;
    push(1'b0, 32'h10, 32'h0);
    wait_rsp("full_rsp_wait");
    base = wn;
    for (int i = 0; i < 4; i++) push(1'b1, 32'h200 + i, 32'hC000_0000 + i);
    check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_address = 32'h204; cmd_data = 32'hC0000004;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("full_held_ready", {31'd0, cmd_ready}, 32'd0);
      check("full_held_wr_count", {16'd0, wr_count}, 32'd4);
    end
    rsp_ready = 1'b1;
    begin
      int n = 0;
      while (!cmd_ready && n < 20) begin tick(); n++; end
    end
    check("full_slot_freed", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    begin
      int n = 0;
      while (wn < base + 5 && n < 60) begin tick(); n++; end
    end
    check("full_issued", wn - base, 32'd5);
    for (int i = 0; i < 5; i++)
      if (base + i < 64) check("full_order", wlog[base + i], 32'h200 + i);
    check("full_wr_count", {16'd0, wr_count}, 32'd9);
    check("full_rd_count", {16'd0, rd_count}, 32'd3);

    // Reset while in WAIT with two commands queued
    push(1'b0, 32'h10, 32'h0);
    push(1'b1, 32'h300, 32'h1);
    push(1'b1, 32'h301, 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = wn;
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'd0);
    check("mid_rst_address", address, 32'd0);
    check("mid_rst_mode", {31'd0, mode}, 32'd0);
    check("mid_rst_rd_count", {16'd0, rd_count}, 32'd0);
    check("mid_rst_wr_count", {16'd0, wr_count}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("mid_rst_no_writes", wn - base, 32'd0);
    check("mid_rst_rsp_quiet", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_counts_quiet", {rd_count, wr_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_requester.md
CACHE_REQUESTER -- requirements
Module: cache_requester

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command queue depth in entries (power of two, 2..16).
REQ-002 SHALL have: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have: rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have: cmd_valid  input  1  client command present.
REQ-005 SHALL have: cmd_ready  output  1  queue can accept a command.
REQ-006 SHALL have: cmd_mode  input  1  1 = write, 0 = read.
REQ-007 SHALL have: cmd_address  input  32  target word address.
REQ-008 SHALL have: cmd_data  input  32  write data (ignored for reads).
REQ-009 SHALL have: rsp_valid  output  1  read result present.
REQ-010 SHALL have: rsp_ready  input  1  client accepts result.
REQ-011 SHALL have: rsp_data  output  32  read result.
REQ-012 SHALL have: rsp_address  output  32  address of the read result.
REQ-013 SHALL have: address  output  32  to cache address port.
REQ-014 SHALL have: data  output  32  to cache data port.
REQ-015 SHALL have: mode  output  1  to cache mode port (1 write, 0 read).
REQ-016 SHALL have: cache_out  input  32  from cache registered read output.
REQ-017 SHALL have: rd_count, wr_count  output  16 each  issued reads / writes.

Function
REQ-018 SHALL push a command into the FIFO on any edge with cmd_valid && cmd_ready; cmd_ready = (occupancy < FIFO_DEPTH), registered-state-based only.
REQ-019 SHALL allow simultaneous push and pop when not full; when full, a same-cycle pop does not raise cmd_ready until the next cycle.
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all cache-facing outputs registered.
REQ-021 IDLE: if FIFO non-empty, pop head, load address/data/mode from it, go ISSUE; else stay, mode = 0, address/data hold last values.
REQ-022 ISSUE: outputs held stable exactly one cycle (cache samples at its end); write -> IDLE with mode cleared to 0 on the same edge, wr_count += 1; read -> WAIT, rd_count += 1.
REQ-023 mode SHALL be 1 for exactly one clock per write command, never otherwise (the cache writes on every edge mode is 1).
REQ-024 WAIT: sample cache_out into rsp_data, address into rsp_address, set rsp_valid, go RESP.
REQ-025 RESP: hold rsp_valid/rsp_data/rsp_address stable until edge with rsp_ready = 1; then clear rsp_valid, go IDLE.
REQ-026 Latency: command accepted at edge E0 into empty FIFO with FSM in IDLE -> ISSUE from E1; cache samples at E2; rsp_valid high from E3; write visible in cache after E2.
REQ-027 Back-to-back writes SHALL issue every 2 cycles; reads every 4 cycles with rsp_ready held 1.
REQ-028 Commands SHALL be issued strictly in acceptance order; responses in read order.
REQ-029 rd_count/wr_count SHALL saturate at 16'hFFFF.

Reset
REQ-030 While rst = 1 at an edge: state IDLE, FIFO emptied (occupancy 0), cmd_ready = 1 after that edge, rsp_valid = 0, rsp_data = 0, rsp_address = 0, address = 0, data = 0, mode = 0, counters = 0.
REQ-031 Reset mid-operation SHALL abort any in-flight command and discard queued commands; rst takes priority over push, pop and rsp_ready.

Verification
REQ-032 Write 0x00000010 <= 0xDEADBEEF then read 0x00000010 -> mode 1 for one cycle, rsp_data = 0xDEADBEEF, rsp_address = 0x10, wr_count = 1, rd_count = 1.
REQ-033 Single read into empty idle block accepted at E0 -> rsp_valid rises after E3, not earlier.
REQ-034 Push 5 commands with FIFO_DEPTH = 4 and FSM stalled in RESP (rsp_ready = 0) -> cmd_ready low after 4th queued entry, 5th held until a slot frees; all 5 issued in order.
REQ-035 Read response with rsp_ready = 0 for 6 cycles -> rsp_valid/rsp_data stable all 6 cycles; next command issues only after acceptance.
REQ-036 Assert rst while in WAIT with 2 queued commands -> next cycle all outputs at reset values, no further mode = 1 pulses, counters 0.
REQ-037 Writes to 0x0 and 0x100 (same cache index, different tag) then read 0x0 -> rsp_data equals value written to 0x0.
